par2ser_feed: RTL and testbench

- Upstream feeder for the serial pattern-detector stage.
- Accepts parallel words over a valid/ready handshake and emits one bit per clock on a serial output, together with a qualifying valid.
- A one-word holding buffer lets back-to-back words stream with no bubble, so the detector sees a continuous bit stream.
- Intended use: drive detector stimulus from word-wide sources (registers, memories, testbench vectors).

---
 rtl/par2ser_feed.sv | 84 ++++++++
 tb/tb_par2ser_feed.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/par2ser_feed.sv
// Parallel-to-serial feeder for the pattern-detector stage: valid/ready word
// input, one bit per clock out, one-word holding buffer for gap-free streaming.
module par2ser_feed #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh, sh_n, hd, hd_n, sh_shift;
  logic [CW-1:0]    cnt, cnt_n;
  logic             sh_vld, sh_vld_n, hd_vld, hd_vld_n;
  logic             accept;

  assign din_ready  = !hd_vld;
  assign dout_valid = sh_vld;
  assign dout       = sh_vld ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : 1'b0;
  assign word_done  = sh_vld && (cnt == LAST);
  assign busy       = sh_vld || hd_vld;
  assign accept     = din_valid && din_ready;

  // Shift toward the output end, zero-fill behind.
  assign sh_shift = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};

  always_comb begin
    sh_n     = sh;
    hd_n     = hd;
    cnt_n    = cnt;
    sh_vld_n = sh_vld;
    hd_vld_n = hd_vld;
    if (!sh_vld) begin
      if (accept) begin
        sh_n     = din;
        cnt_n    = '0;
        sh_vld_n = 1'b1;
      end
    end else if (cnt != LAST) begin
      sh_n  = sh_shift;
      cnt_n = cnt + 1'b1;
      if (accept) begin
        hd_n     = din;
        hd_vld_n = 1'b1;
      end
    end else if (hd_vld) begin
      // din_ready is low here, so nothing can be accepted on this edge.
      sh_n     = hd;
      cnt_n    = '0;
      hd_vld_n = 1'b0;
    end else if (accept) begin
      sh_n  = din;
      cnt_n = '0;
    end else begin
      sh_vld_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh     <= '0;
      hd     <= '0;
      cnt    <= '0;
      sh_vld <= 1'b0;
      hd_vld <= 1'b0;
    end else begin
      sh     <= sh_n;
      hd     <= hd_n;
      cnt    <= cnt_n;
      sh_vld <= sh_vld_n;
      hd_vld <= hd_vld_n;
    end
  end

endmodule

// File: tb/tb_par2ser_feed.sv
// Directed bench for par2ser_feed: MSB-first vector table plus an LSB-first
// sequence exercising the direct-load path on the last-bit edge.
module tb_par2ser_feed;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;

  logic m_ready, m_dout, m_dvld, m_wd, m_busy;
  logic l_ready, l_dout, l_dvld, l_wd, l_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  par2ser_feed #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(m_ready), .dout(m_dout), .dout_valid(m_dvld),
    .word_done(m_wd), .busy(m_busy)
  );

  par2ser_feed #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(l_ready), .dout(l_dout), .dout_valid(l_dvld),
    .word_done(l_wd), .busy(l_busy)
  );

  // e = {dout, dout_valid, word_done, busy, din_ready} after the edge
  typedef struct {
    logic       r;
    logic [7:0] d;
    logic       v;
    logic [4:0] e;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [7:0] d, input logic v, input logic [4:0] e);
    vec_t x;
    x.r = r; x.d = d; x.v = v; x.e = e;
    tbl.push_back(x);
  endtask

  task automatic sb(input logic r, input logic [7:0] d, input logic v,
                    input logic b, input logic wd, input logic rdy);
    add(r, d, v, {b, 1'b1, wd, 1'b1, rdy});
  endtask

  task automatic idl(input logic r, input logic [7:0] d, input logic v);
    add(r, d, v, 5'b00001);
  endtask

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {dout,dvld,wd,busy,rdy}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] d, input logic v);
    @(negedge clk);
    rst = r; din = d; din_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w;

    // reset state
    idl(0, 8'h00, 0);
    // single word DB
    w = 8'hDB;
    for (int k = 0; k < 8; k++)
      sb(1, (k == 0) ? w : 8'h00, k == 0, w[7-k], k == 7, 1);
    idl(1, 8'h00, 0);
    // back-to-back DB, D8, with FF held under backpressure
    sb(1, 8'hDB, 1, 1, 0, 1);
    sb(1, 8'hD8, 1, 1, 0, 0);
    for (int k = 2; k < 8; k++)
      sb(1, 8'hFF, 1, w[7-k], k == 7, 0);
    w = 8'hD8;
    sb(1, 8'hFF, 1, w[7], 0, 1);
    sb(1, 8'hFF, 1, w[6], 0, 0);
    for (int k = 2; k < 8; k++)
      sb(1, 8'h00, 0, w[7-k], k == 7, 0);
    for (int k = 0; k < 8; k++)
      sb(1, 8'h00, 0, 1, k == 7, 1);
    idl(1, 8'h00, 0);
    // reset mid-word with a word held, then clean 1B
    sb(1, 8'hDB, 1, 1, 0, 1);
    sb(1, 8'hD8, 1, 1, 0, 0);
    sb(1, 8'hD8, 1, 0, 0, 0);
    sb(1, 8'hD8, 1, 1, 0, 0);
    idl(0, 8'hD8, 1);
    w = 8'h1B;
    for (int k = 0; k < 8; k++)
      sb(1, (k == 0) ? w : 8'h00, k == 0, w[7-k], k == 7, 1);
    idl(1, 8'h00, 0);
    // idle gap between two words
    w = 8'hA5;
    for (int k = 0; k < 8; k++)
      sb(1, (k == 0) ? w : 8'h00, k == 0, w[7-k], k == 7, 1);
    for (int k = 0; k < 5; k++)
      idl(1, 8'h00, 0);
    w = 8'h3C;
    for (int k = 0; k < 8; k++)
      sb(1, (k == 0) ? w : 8'h00, k == 0, w[7-k], k == 7, 1);
    idl(1, 8'h00, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].d, tbl[i].v);
      chk($sformatf("msb_vec%0d", i), {m_dout, m_dvld, m_wd, m_busy, m_ready}, tbl[i].e);
    end

    // LSB-first 0B, then 81 loaded directly on the last-bit edge
    drive(0, 8'h00, 0);
    chk("lsb_reset", {l_dout, l_dvld, l_wd, l_busy, l_ready}, 5'b00001);
    w = 8'h0B;
    for (int k = 0; k < 8; k++) begin
      drive(1, (k == 0) ? w : 8'h00, k == 0);
      chk($sformatf("lsb_0B_bit%0d", k), {l_dout, l_dvld, l_wd, l_busy, l_ready},
          {w[k], 1'b1, k == 7, 1'b1, 1'b1});
    end
    w = 8'h81;
    for (int k = 0; k < 8; k++) begin
      drive(1, (k == 0) ? w : 8'h00, k == 0);
      chk($sformatf("lsb_81_bit%0d", k), {l_dout, l_dvld, l_wd, l_busy, l_ready},
          {w[k], 1'b1, k == 7, 1'b1, 1'b1});
    end
    drive(1, 8'h00, 0);
    chk("lsb_idle", {l_dout, l_dvld, l_wd, l_busy, l_ready}, 5'b00001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
